// File: rtl/mac_sequencer.sv
// Sequencer for one lane of the SIMD fixed-point multiply unit: MAC reduce, elementwise MUL and conditional MUL.
// Optional MAC_BIAS_EN adds cmd_bias, which seeds the accumulator at command accept.
module mac_sequencer #(
    parameter int BIT_WIDTH     = 32,
    parameter int OPCODE_BITS   = 4,
    parameter int FUNCTION_BITS = 4,
    parameter int LEN_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [LEN_BITS-1:0]      cmd_len,
    input  logic [7:0]               cmd_dest_int_bits,
    input  logic [7:0]               cmd_src1_int_bits,
    input  logic [7:0]               cmd_src2_int_bits,
`ifdef MAC_BIAS_EN
    input  logic [BIT_WIDTH-1:0]     cmd_bias,
`endif
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [BIT_WIDTH-1:0]     op_a,
    input  logic [BIT_WIDTH-1:0]     op_b,
    output logic [OPCODE_BITS-1:0]   mu_opcode,
    output logic [FUNCTION_BITS-1:0] mu_fn,
    output logic [BIT_WIDTH-1:0]     mu_data_in0,
    output logic [BIT_WIDTH-1:0]     mu_data_in1,
    output logic [BIT_WIDTH-1:0]     mu_data_acc,
    output logic [7:0]               mu_dest_int_bits,
    output logic [7:0]               mu_src1_int_bits,
    output logic [7:0]               mu_src2_int_bits,
    input  logic [BIT_WIDTH-1:0]     mu_data_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [BIT_WIDTH-1:0]     res_data,
    output logic                     res_last,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;
    localparam logic [1:0] MODE_MAC  = 2'd0;
    localparam logic [1:0] MODE_MUL  = 2'd1;
    localparam logic [1:0] MODE_COND = 2'd2;

    state_t               state, state_next;
    logic [1:0]           mode;
    logic [LEN_BITS-1:0]  count;
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] acc_init;
    logic                 out_pending;
    logic                 cmd_fire, op_fire, last_op, res_free, is_mac;

`ifdef MAC_BIAS_EN
    assign acc_init = cmd_bias;
`else
    assign acc_init = '0;
`endif

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign op_fire     = op_valid && op_ready;
    assign last_op     = (count == LEN_BITS'(1));
    assign res_free    = !res_valid || res_ready;
    assign is_mac      = (mode == MODE_MAC);
    assign mu_data_in0 = op_a;
    assign mu_data_in1 = op_b;
    assign mu_data_acc = acc;
    assign busy        = (state != IDLE) || res_valid;
    assign dbg_state   = state;

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // a producer holds its payload stable while valid is high and ready is low.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        op_ready   = 1'b0;
        mu_opcode  = '0;
        mu_fn      = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len != '0)
                        state_next = RUN;
                    else if (cmd_mode == MODE_MAC)
                        state_next = OUT;
                end
            end
            RUN: begin
                // The final MAC pair needs a free result register so its sum lands there directly.
                op_ready = is_mac ? (!last_op || res_free) : res_free;
                if (op_fire && last_op)
                    state_next = is_mac ? OUT : IDLE;
            end
            OUT: begin
                if (!out_pending && res_valid && res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE) begin
            case (mode)
                MODE_MAC:  begin mu_opcode = OPCODE_BITS'(0); mu_fn = FUNCTION_BITS'(3); end
                MODE_COND: begin mu_opcode = OPCODE_BITS'(1); mu_fn = FUNCTION_BITS'(1); end
                default:   begin mu_opcode = OPCODE_BITS'(0); mu_fn = FUNCTION_BITS'(2); end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            mode             <= MODE_MAC;
            count            <= '0;
            acc              <= '0;
            out_pending      <= 1'b0;
            mu_dest_int_bits <= '0;
            mu_src1_int_bits <= '0;
            mu_src2_int_bits <= '0;
            res_valid        <= 1'b0;
            res_data         <= '0;
            res_last         <= 1'b0;
        end else begin
            state <= state_next;
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        mode             <= (cmd_mode == 2'd3) ? MODE_MUL : cmd_mode;
                        count            <= cmd_len;
                        acc              <= acc_init;
                        mu_dest_int_bits <= cmd_dest_int_bits;
                        mu_src1_int_bits <= cmd_src1_int_bits;
                        mu_src2_int_bits <= cmd_src2_int_bits;
                        if (cmd_len == '0 && cmd_mode == MODE_MAC) begin
                            // An empty reduction may find an elementwise result still pending.
                            if (res_free) begin
                                res_valid   <= 1'b1;
                                res_data    <= acc_init;
                                res_last    <= 1'b1;
                                out_pending <= 1'b0;
                            end else begin
                                out_pending <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (op_fire) begin
                        count     <= count - LEN_BITS'(1);
                        if (is_mac) begin
                            acc <= mu_data_out;
                            if (last_op) begin
                                res_valid   <= 1'b1;
                                res_data    <= mu_data_out;
                                res_last    <= 1'b1;
                                out_pending <= 1'b0;
                            end
                        end else begin
                            res_valid <= 1'b1;
                            res_data  <= mu_data_out;
                            res_last  <= last_op;
                        end
                    end
                end
                OUT: begin
                    if (out_pending) begin
                        if (res_free) begin
                            res_valid   <= 1'b1;
                            res_data    <= acc;
                            res_last    <= 1'b1;
                            out_pending <= 1'b0;
                        end
                    end else if (res_valid && res_ready) begin
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural fixed-point multiply unit beside it.
// Compile with +define+MAC_BIAS_EN to exercise the cmd_bias variant.
module tb_mac_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_dest_int_bits, cmd_src1_int_bits, cmd_src2_int_bits;
`ifdef MAC_BIAS_EN
  logic [31:0] cmd_bias;
`endif
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [3:0]  mu_opcode, mu_fn;
  logic [31:0] mu_data_in0, mu_data_in1, mu_data_acc, mu_data_out;
  logic [7:0]  mu_dest_int_bits, mu_src1_int_bits, mu_src2_int_bits;
  logic        res_valid, res_ready, res_last, busy;
  logic [31:0] res_data;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  mac_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .cmd_dest_int_bits(cmd_dest_int_bits), .cmd_src1_int_bits(cmd_src1_int_bits),
    .cmd_src2_int_bits(cmd_src2_int_bits),
`ifdef MAC_BIAS_EN
    .cmd_bias(cmd_bias),
`endif
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mu_opcode(mu_opcode), .mu_fn(mu_fn),
    .mu_data_in0(mu_data_in0), .mu_data_in1(mu_data_in1), .mu_data_acc(mu_data_acc),
    .mu_dest_int_bits(mu_dest_int_bits), .mu_src1_int_bits(mu_src1_int_bits),
    .mu_src2_int_bits(mu_src2_int_bits), .mu_data_out(mu_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Behavioural multiply unit: product realigned to the destination format, saturated
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  logic signed [63:0] mu_p, mu_prod;
  int mu_sh;
  always_comb begin
    mu_p    = 64'($signed(mu_data_in0)) * 64'($signed(mu_data_in1));
    mu_sh   = 32 + int'(mu_dest_int_bits) - int'(mu_src1_int_bits) - int'(mu_src2_int_bits);
    mu_prod = mu_p >>> mu_sh;
    mu_data_out = 32'h0;
    if (mu_opcode == 4'd0 && mu_fn == 4'd2)
      mu_data_out = sat32(mu_prod);
    else if (mu_opcode == 4'd0 && mu_fn == 4'd3)
      mu_data_out = sat32(64'($signed(mu_data_acc)) + mu_prod);
    else if (mu_opcode == 4'd1 && mu_fn == 4'd1)
      mu_data_out = ($signed(mu_data_in0) >= 0) ? mu_data_in0 : sat32(mu_prod);
  end

  // Driver tasks
  task automatic send_cmd(input logic [1:0] mode, input logic [15:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_len = len;
    cmd_dest_int_bits = 8'd16; cmd_src1_int_bits = 8'd16; cmd_src2_int_bits = 8'd16;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL cmd_ready_at_issue: got %b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic put_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!op_ready) begin
      fails++; $display("FAIL op_handshake: op_ready got %b want 1 within 50 cycles", op_ready);
    end else begin
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL rst_op_ready: got %b want 0", op_ready); end
    tests++; if (mu_opcode !== 4'd0 || mu_fn !== 4'd0) begin fails++; $display("FAIL rst_mu_op: got %h/%h want 0/0", mu_opcode, mu_fn); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_last !== 1'b0) begin
      fails++; $display("FAIL rst_result: got v=%b d=%h l=%b want 0/0/0", res_valid, res_data, res_last);
    end
    tests++; if (dbg_state !== 2'd0 || mu_data_acc !== 32'h0) begin
      fails++; $display("FAIL rst_state_acc: got st=%0d acc=%h want 0/0", dbg_state, mu_data_acc);
    end
  endtask

  task automatic test_mac();
    res_ready = 1'b0;
    send_cmd(2'd0, 16'd3);
    tests++; if (mu_opcode !== 4'd0 || mu_fn !== 4'd3) begin fails++; $display("FAIL mac_mu_op: got %h/%h want 0/3", mu_opcode, mu_fn); end
    tests++; if (mu_dest_int_bits !== 8'd16 || mu_src1_int_bits !== 8'd16 || mu_src2_int_bits !== 8'd16) begin
      fails++; $display("FAIL mac_formats: got %0d/%0d/%0d want 16/16/16", mu_dest_int_bits, mu_src1_int_bits, mu_src2_int_bits);
    end
    put_op(32'h0001_0000, 32'h0002_0000);
    put_op(32'h0001_0000, 32'h0003_0000);
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL mac_early_result: res_valid got %b want 0", res_valid); end
    put_op(32'h0001_0000, 32'h0004_0000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0009_0000 || res_last !== 1'b1) begin
      fails++; $display("FAIL mac_result: got v=%b d=%h l=%b want 1/00090000/1", res_valid, res_data, res_last);
    end
    repeat (2) @(posedge clk); #1;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0009_0000) begin
      fails++; $display("FAIL mac_hold: got v=%b d=%h want 1/00090000", res_valid, res_data);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL mac_drain: got v=%b busy=%b cr=%b want 0/0/1", res_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_mul();
    res_ready = 1'b1;
    send_cmd(2'd1, 16'd2);
    tests++; if (mu_opcode !== 4'd0 || mu_fn !== 4'd2) begin fails++; $display("FAIL mul_mu_op: got %h/%h want 0/2", mu_opcode, mu_fn); end
    put_op(32'h0002_0000, 32'h0003_0000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0006_0000 || res_last !== 1'b0) begin
      fails++; $display("FAIL mul_r0: got v=%b d=%h l=%b want 1/00060000/0", res_valid, res_data, res_last);
    end
    put_op(32'hFFFF_0000, 32'h0002_0000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'hFFFE_0000 || res_last !== 1'b1) begin
      fails++; $display("FAIL mul_r1: got v=%b d=%h l=%b want 1/fffe0000/1", res_valid, res_data, res_last);
    end
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mul_drain: got v=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_cond();
    res_ready = 1'b1;
    send_cmd(2'd2, 16'd2);
    tests++; if (mu_opcode !== 4'd1 || mu_fn !== 4'd1) begin fails++; $display("FAIL cond_mu_op: got %h/%h want 1/1", mu_opcode, mu_fn); end
    put_op(32'h0001_0000, 32'h0005_0000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0001_0000 || res_last !== 1'b0) begin
      fails++; $display("FAIL cond_pass: got v=%b d=%h l=%b want 1/00010000/0", res_valid, res_data, res_last);
    end
    put_op(32'hFFFF_0000, 32'h0000_8000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_8000 || res_last !== 1'b1) begin
      fails++; $display("FAIL cond_mul: got v=%b d=%h l=%b want 1/ffff8000/1", res_valid, res_data, res_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int got;
    logic [31:0] want;
    logic last_seen;
    res_ready = 1'b0;
    got = 0;
    last_seen = 1'b0;
    send_cmd(2'd1, 16'd4);
    put_op(32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    op_valid = 1'b1; op_a = 32'h0002_0000; op_b = 32'h0001_0000;
    repeat (3) @(negedge clk);
    tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL bp_op_ready: got %b want 0", op_ready); end
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0001_0000) begin
      fails++; $display("FAIL bp_hold: got v=%b d=%h want 1/00010000", res_valid, res_data);
    end
    op_valid = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i) << 16);
    res_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < 40 && got < 4; c++) begin
          if (res_valid) begin
            got++;
            last_seen = res_last;
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL bp_extra: got %h want no further result", res_data);
            end else begin
              want = exp_q.pop_front();
              if (res_data !== want || res_last !== (got == 4)) begin
                fails++; $display("FAIL bp_order: got d=%h l=%b want %h/%b", res_data, res_last, want, got == 4);
              end
            end
          end
          @(negedge clk);
        end
      end
      begin
        put_op(32'h0002_0000, 32'h0001_0000);
        put_op(32'h0003_0000, 32'h0001_0000);
        put_op(32'h0004_0000, 32'h0001_0000);
      end
    join
    tests++; if (got != 4 || last_seen !== 1'b1) begin
      fails++; $display("FAIL bp_count: got %0d results last=%b want 4/1", got, last_seen);
    end
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_idle: got v=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] want;
`ifdef MAC_BIAS_EN
    cmd_bias = 32'h1234_5678;
    want = 32'h1234_5678;
`else
    want = 32'h0;
`endif
    res_ready = 1'b0;
    send_cmd(2'd0, 16'd0);
    tests++; if (res_valid !== 1'b1 || res_data !== want || res_last !== 1'b1) begin
      fails++; $display("FAIL len0_mac: got v=%b d=%h l=%b want 1/%h/1", res_valid, res_data, res_last, want);
    end
`ifdef MAC_BIAS_EN
    cmd_bias = 32'h0;
`endif
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL len0_mac_drain: got v=%b cr=%b want 0/1", res_valid, cmd_ready);
    end
    send_cmd(2'd1, 16'd0);
    tests++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL len0_mul: got v=%b cr=%b busy=%b want 0/1/0", res_valid, cmd_ready, busy);
    end
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL len0_mul_late: res_valid got %b want 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    send_cmd(2'd0, 16'd5);
    put_op(32'h0001_0000, 32'h0002_0000);
    put_op(32'h0001_0000, 32'h0003_0000);
    @(negedge clk); reset_n = 1'b0;
    #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
      fails++; $display("FAIL midrst: got v=%b busy=%b cr=%b st=%0d want 0/0/1/0", res_valid, busy, cmd_ready, dbg_state);
    end
    @(negedge clk); reset_n = 1'b1;
    send_cmd(2'd0, 16'd1);
    put_op(32'h0001_0000, 32'h0001_0000);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0001_0000 || res_last !== 1'b1) begin
      fails++; $display("FAIL midrst_next: got v=%b d=%h l=%b want 1/00010000/1", res_valid, res_data, res_last);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    send_cmd(2'd1, 16'd1);
    put_op(32'h0003_0000, 32'h0001_0000);
    send_cmd(2'd1, 16'd1);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0003_0000) begin
      fails++; $display("FAIL b2b_pending: got v=%b d=%h want 1/00030000", res_valid, res_data);
    end
    @(negedge clk);
    op_valid = 1'b1; op_a = 32'h0004_0000; op_b = 32'h0001_0000;
    #1;
    tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL b2b_blocked: op_ready got %b want 0", op_ready); end
    res_ready = 1'b1;
    #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL b2b_freed: op_ready got %b want 1", op_ready); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0004_0000 || res_last !== 1'b1) begin
      fails++; $display("FAIL b2b_reload: got v=%b d=%h l=%b want 1/00040000/1", res_valid, res_data, res_last);
    end
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got v=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_len = 16'd0;
    cmd_dest_int_bits = 8'd0; cmd_src1_int_bits = 8'd0; cmd_src2_int_bits = 8'd0;
`ifdef MAC_BIAS_EN
    cmd_bias = 32'h0;
`endif
    op_valid = 1'b0; op_a = 32'h0; op_b = 32'h0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_mac();
    test_mul();
    test_cond();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
